// File: rtl/op_pkg.sv
// Shared fetch-path widths and types: FSM states and the queue entry layout.
package op_pkg;
    localparam int INSTRUCTION_WIDTH  = 32;
    localparam int SUPER_SCALAR_WIDTH = 4;
    localparam int FETCH_PC_WIDTH     = 64;
    localparam int SSW_CNT_W          = $clog2(SUPER_SCALAR_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_L1I,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [INSTRUCTION_WIDTH-1:0] instr;
        logic [FETCH_PC_WIDTH-1:0]    pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_line_extract.sv
// Combinational slicer: picks up to SUPER_SCALAR_WIDTH little-endian words from a
// cache line starting at the PC's word offset, stopping at the end of the line.
module fetch_line_extract
    import op_pkg::*;
#(
    parameter int CACHE_LINE_WIDTH = 64,
    parameter int PC_WIDTH         = 64
) (
    input  logic [8*CACHE_LINE_WIDTH-1:0]                     line,
    input  logic [PC_WIDTH-1:0]                               pc,
    output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instrs,
    output logic [SUPER_SCALAR_WIDTH-1:0][PC_WIDTH-1:0]          pcs,
    output logic [SSW_CNT_W-1:0]                              count
);
    localparam int WORDS  = CACHE_LINE_WIDTH / 4;
    localparam int WIDX_W = $clog2(WORDS);
    localparam int WL     = WIDX_W + 1;
    localparam logic [WIDX_W:0] WORDS_C = WL'(WORDS);
    localparam logic [WIDX_W:0] SSW_C   = WL'(SUPER_SCALAR_WIDTH);

    logic [WIDX_W-1:0]            word_idx;
    logic [WIDX_W:0]              words_left;
    logic [PC_WIDTH-1:0]          pc_aligned;
    logic                         pc_lo_unused;
    logic [INSTRUCTION_WIDTH-1:0] words [WORDS];

    assign word_idx     = pc[WIDX_W+1:2];
    assign words_left   = WORDS_C - {1'b0, word_idx};
    assign count        = (words_left >= SSW_C) ? SSW_CNT_W'(SUPER_SCALAR_WIDTH)
                                                : SSW_CNT_W'(words_left);
    assign pc_aligned   = {pc[PC_WIDTH-1:2], 2'b00};
    assign pc_lo_unused = ^pc[1:0];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign words[gi] = line[gi*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
        end
        // Slots past the line end are zeroed; the wrapped index there is never used.
        for (genvar gi = 0; gi < SUPER_SCALAR_WIDTH; gi++) begin : g_slot
            logic slot_ok;
            assign slot_ok    = SSW_CNT_W'(gi) < count;
            assign instrs[gi] = slot_ok ? words[word_idx + WIDX_W'(gi)] : '0;
            assign pcs[gi]    = slot_ok ? pc_aligned + PC_WIDTH'(4 * gi) : '0;
        end
    endgenerate
endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: L0/L1I line extraction into an instruction queue feeding decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue_unit
    import op_pkg::*;
#(
    parameter int CACHE_LINE_WIDTH = 64,
    parameter int QUEUE_DEPTH      = 16,
    parameter int PC_WIDTH         = 64,
    parameter int PERF_CNT_WIDTH   = 32
) (
    input  logic                                                clk_in,
    input  logic                                                rst_in,
    input  logic                                                flush_in,
    input  logic                                                pc_valid_in,
    input  logic [PC_WIDTH-1:0]                                 pred_pc_in,
    output logic                                                fetch_ready_out,
    input  logic                                                l0_valid_in,
    input  logic [8*CACHE_LINE_WIDTH-1:0]                       l0_cacheline_in,
    input  logic                                                l1i_valid_in,
    input  logic [8*CACHE_LINE_WIDTH-1:0]                       l1i_cacheline_in,
    input  logic                                                decode_ready_in,
    output logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instrs_out,
    output logic [SUPER_SCALAR_WIDTH-1:0][PC_WIDTH-1:0]          instr_pcs_out,
    output logic [SUPER_SCALAR_WIDTH-1:0]                        instr_valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0]                           perf_l0_hit_out,
    output logic [PERF_CNT_WIDTH-1:0]                           perf_l1i_miss_out,
    output logic [PERF_CNT_WIDTH-1:0]                           perf_stall_out,
    output logic [PERF_CNT_WIDTH-1:0]                           perf_flush_out
`endif
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] SSW_C   = CNT_W'(SUPER_SCALAR_WIDTH);

    fetch_state_e        state_reg, state_next;
    logic [PC_WIDTH-1:0] miss_pc_reg;
    logic [PTR_W-1:0]    head_reg, tail_reg;
    logic [CNT_W-1:0]    count_reg, free_slots;
    fetch_entry_t        queue_mem [QUEUE_DEPTH];

    logic [SUPER_SCALAR_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] l0_instrs, l1_instrs, enq_instrs;
    logic [SUPER_SCALAR_WIDTH-1:0][PC_WIDTH-1:0]          l0_pcs, l1_pcs, enq_pcs;
    logic [SSW_CNT_W-1:0] l0_n, l1_n, enq_n, deq_n;
    logic                 accept, enq_l0, enq_l1, latch_miss;

    fetch_line_extract #(.CACHE_LINE_WIDTH(CACHE_LINE_WIDTH), .PC_WIDTH(PC_WIDTH)) u_l0_extract (
        .line(l0_cacheline_in), .pc(pred_pc_in), .instrs(l0_instrs), .pcs(l0_pcs), .count(l0_n)
    );
    fetch_line_extract #(.CACHE_LINE_WIDTH(CACHE_LINE_WIDTH), .PC_WIDTH(PC_WIDTH)) u_l1_extract (
        .line(l1i_cacheline_in), .pc(miss_pc_reg), .instrs(l1_instrs), .pcs(l1_pcs), .count(l1_n)
    );

    assign free_slots      = DEPTH_C - count_reg;
    assign fetch_ready_out = (state_reg == IDLE) && (free_slots >= SSW_C) && !flush_in && !rst_in;
    assign accept          = pc_valid_in && fetch_ready_out;

    always_comb begin
        state_next = state_reg;
        enq_l0     = 1'b0;
        enq_l1     = 1'b0;
        latch_miss = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (l0_valid_in) begin
                        enq_l0 = 1'b1;
                    end else begin
                        latch_miss = 1'b1;
                        state_next = WAIT_L1I;
                    end
                end
            end
            WAIT_L1I: begin
                // A fill racing a flush is dropped; without a fill the stale one must be absorbed later.
                if (flush_in) begin
                    state_next = l1i_valid_in ? IDLE : DISCARD;
                end else if (l1i_valid_in) begin
                    enq_l1     = 1'b1;
                    state_next = IDLE;
                end
            end
            DISCARD: begin
                if (!flush_in && l1i_valid_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign enq_n      = enq_l0 ? l0_n : (enq_l1 ? l1_n : '0);
    assign enq_instrs = enq_l1 ? l1_instrs : l0_instrs;
    assign enq_pcs    = enq_l1 ? l1_pcs : l0_pcs;
    assign deq_n      = !decode_ready_in ? '0 :
                        (count_reg >= SSW_C) ? SSW_CNT_W'(SUPER_SCALAR_WIDTH) : SSW_CNT_W'(count_reg);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg   <= IDLE;
            miss_pc_reg <= '0;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_miss) miss_pc_reg <= pred_pc_in;
            if (flush_in) begin
                head_reg  <= '0;
                tail_reg  <= '0;
                count_reg <= '0;
            end else begin
                head_reg  <= head_reg + PTR_W'(deq_n);
                tail_reg  <= tail_reg + PTR_W'(enq_n);
                count_reg <= count_reg + CNT_W'(enq_n) - CNT_W'(deq_n);
            end
        end
    end

    // Storage needs no reset: every read is masked by the occupancy count.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
            if (SSW_CNT_W'(i) < enq_n)
                queue_mem[tail_reg + PTR_W'(i)] <= '{instr: enq_instrs[i], pc: FETCH_PC_WIDTH'(enq_pcs[i])};
        end
    end

    generate
        for (genvar gi = 0; gi < SUPER_SCALAR_WIDTH; gi++) begin : g_head
            fetch_entry_t head_entry;
            assign head_entry          = queue_mem[head_reg + PTR_W'(gi)];
            assign instr_valid_out[gi] = count_reg > CNT_W'(gi);
            assign instrs_out[gi]      = instr_valid_out[gi] ? head_entry.instr : '0;
            assign instr_pcs_out[gi]   = instr_valid_out[gi] ? PC_WIDTH'(head_entry.pc) : '0;
        end
    endgenerate

`ifdef FETCH_PERF_CNT_EN
    logic [3:0]                perf_evt;
    logic [PERF_CNT_WIDTH-1:0] perf_cnt_reg [4];

    assign perf_evt = {flush_in, pc_valid_in & ~fetch_ready_out, latch_miss, enq_l0};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 4; i++) perf_cnt_reg[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (perf_evt[i] && !(&perf_cnt_reg[i]))
                    perf_cnt_reg[i] <= perf_cnt_reg[i] + PERF_CNT_WIDTH'(1);
            end
        end
    end

    assign perf_l0_hit_out   = perf_cnt_reg[0];
    assign perf_l1i_miss_out = perf_cnt_reg[1];
    assign perf_stall_out    = perf_cnt_reg[2];
    assign perf_flush_out    = perf_cnt_reg[3];
`endif
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue_unit;
    import op_pkg::*;

    localparam int CLW = 64;
    localparam int QD  = 16;
    localparam int PCW = 64;
    localparam int SSW = SUPER_SCALAR_WIDTH;

    typedef logic [7:0] line_t [CLW];
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    logic clk_in = 1'b0;
    logic rst_in, flush_in, pc_valid_in, l0_valid_in, l1i_valid_in, decode_ready_in;
    logic [PCW-1:0]       pred_pc_in;
    logic [8*CLW-1:0]     l0_cacheline_in, l1i_cacheline_in;
    logic                 fetch_ready_out;
    logic [SSW-1:0][31:0]  instrs_out;
    logic [SSW-1:0][PCW-1:0] instr_pcs_out;
    logic [SSW-1:0]        instr_valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_l0_hit_out, perf_l1i_miss_out, perf_stall_out, perf_flush_out;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: a plain FIFO of instructions plus a fetch mode
    // (0 = taking requests, 1 = awaiting miss fill, 2 = awaiting stale fill).
    ent_t        mq[$];
    int          m_mode;
    logic [63:0] m_pc;
    line_t       l0_bytes, l1_bytes;
    logic        ready_seen, exp_ready;

    always #5 clk_in = ~clk_in;

    fetch_queue_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .pc_valid_in(pc_valid_in), .pred_pc_in(pred_pc_in), .fetch_ready_out(fetch_ready_out),
        .l0_valid_in(l0_valid_in), .l0_cacheline_in(l0_cacheline_in),
        .l1i_valid_in(l1i_valid_in), .l1i_cacheline_in(l1i_cacheline_in),
        .decode_ready_in(decode_ready_in), .instrs_out(instrs_out),
        .instr_pcs_out(instr_pcs_out), .instr_valid_out(instr_valid_out)
`ifdef FETCH_PERF_CNT_EN
        , .perf_l0_hit_out(perf_l0_hit_out), .perf_l1i_miss_out(perf_l1i_miss_out),
        .perf_stall_out(perf_stall_out), .perf_flush_out(perf_flush_out)
`endif
    );

    function automatic logic [8*CLW-1:0] pack(input line_t b);
        logic [8*CLW-1:0] v;
        for (int k = 0; k < CLW; k++) v[8*k +: 8] = b[k];
        return v;
    endfunction

    function automatic logic [31:0] word_at(input line_t b, input int o);
        return {b[o+3], b[o+2], b[o+1], b[o]};
    endfunction

    task automatic randomize_lines();
        for (int k = 0; k < CLW; k++) begin
            l0_bytes[k] = 8'($urandom);
            l1_bytes[k] = 8'($urandom);
        end
    endtask

    task automatic push_line(input line_t b, input logic [63:0] pc);
        int   off;
        ent_t e;
        off = int'(pc[5:0]) & ~3;
        for (int i = 0; i < SSW && off + 4*i + 4 <= CLW; i++) begin
            e.instr = word_at(b, off + 4*i);
            e.pc    = {pc[63:2], 2'b00} + 64'(4*i);
            mq.push_back(e);
        end
    endtask

    // One clock: drive inputs, sample ready before the edge, advance the model, land at posedge+1.
    task automatic step(input logic f, input logic pv, input logic [63:0] pc,
                        input logic l0v, input logic l1v, input logic dr);
        int n;
        flush_in = f; pc_valid_in = pv; pred_pc_in = pc;
        l0_valid_in = l0v; l1i_valid_in = l1v; decode_ready_in = dr;
        l0_cacheline_in  = pack(l0_bytes);
        l1i_cacheline_in = pack(l1_bytes);
        #1;
        ready_seen = fetch_ready_out;
        exp_ready  = (m_mode == 0) && (QD - mq.size() >= SSW) && !f;
        if (f) begin
            mq.delete();
            if (m_mode == 1) m_mode = l1v ? 0 : 2;
        end else begin
            n = dr ? ((mq.size() < SSW) ? mq.size() : SSW) : 0;
            repeat (n) void'(mq.pop_front());
            if (m_mode == 0) begin
                if (pv && exp_ready) begin
                    if (l0v) push_line(l0_bytes, pc);
                    else begin
                        m_pc   = pc;
                        m_mode = 1;
                    end
                end
            end else if (l1v) begin
                if (m_mode == 1) push_line(l1_bytes, m_pc);
                m_mode = 0;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; flush_in = 0; pc_valid_in = 0; pred_pc_in = '0;
        l0_valid_in = 0; l1i_valid_in = 0; decode_ready_in = 0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mq.delete();
        m_mode = 0;
        m_pc   = '0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (instr_valid_out !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", instr_valid_out); end
        checks++; if (fetch_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_after_release: got %b expected 1", fetch_ready_out); end
        randomize_lines();
        step(0, 1, 64'h1000, 1, 0, 0);
        rst_in = 1'b1;
        #1;
        checks++; if (instr_valid_out !== 4'b0000) begin errors++; $display("FAIL async_reset_valid: got %b expected 0000", instr_valid_out); end
        checks++; if (instrs_out !== '0) begin errors++; $display("FAIL async_reset_instrs: got %h expected 0", instrs_out); end
        checks++; if (instr_pcs_out !== '0) begin errors++; $display("FAIL async_reset_pcs: got %h expected 0", instr_pcs_out); end
        checks++; if (fetch_ready_out !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got %b expected 0", fetch_ready_out); end
        do_reset();
    endtask

    task automatic test_l0_hit();
        do_reset();
        randomize_lines();
        step(0, 1, 64'h1000, 1, 0, 1);
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL hit_ready: got %b expected 1", ready_seen); end
        checks++; if (instr_valid_out !== 4'b1111) begin errors++; $display("FAIL hit_valid: got %b expected 1111", instr_valid_out); end
        for (int i = 0; i < SSW; i++) begin
            checks++;
            if (instr_pcs_out[i] !== 64'h1000 + 64'(4*i) || instrs_out[i] !== word_at(l0_bytes, 4*i)) begin
                errors++;
                $display("FAIL hit_slot%0d: got pc %h instr %h expected pc %h instr %h", i,
                         instr_pcs_out[i], instrs_out[i], 64'h1000 + 64'(4*i), word_at(l0_bytes, 4*i));
            end
        end
        step(0, 0, 64'h0, 0, 0, 1);
        checks++; if (instr_valid_out !== 4'b0000) begin errors++; $display("FAIL hit_drain: got %b expected 0000", instr_valid_out); end
    endtask

    task automatic test_line_end();
        do_reset();
        randomize_lines();
        step(0, 1, 64'h1038, 1, 0, 1);
        checks++; if (instr_valid_out !== 4'b0011) begin errors++; $display("FAIL end_valid: got %b expected 0011", instr_valid_out); end
        checks++;
        if (instr_pcs_out[0] !== 64'h1038 || instr_pcs_out[1] !== 64'h103C ||
            instrs_out[0] !== word_at(l0_bytes, 56) || instrs_out[1] !== word_at(l0_bytes, 60)) begin
            errors++;
            $display("FAIL end_slots: got pcs %h/%h instrs %h/%h expected 1038/103c %h/%h", instr_pcs_out[0],
                     instr_pcs_out[1], instrs_out[0], instrs_out[1], word_at(l0_bytes, 56), word_at(l0_bytes, 60));
        end
        checks++; if (instrs_out[3:2] !== '0 || instr_pcs_out[3:2] !== '0) begin errors++; $display("FAIL end_past_line: got %h %h expected 0", instrs_out[3:2], instr_pcs_out[3:2]); end
        step(0, 1, 64'h107F, 1, 0, 1);
        checks++;
        if (instr_valid_out !== 4'b0001 || instr_pcs_out[0] !== 64'h107C || instrs_out[0] !== word_at(l0_bytes, 60)) begin
            errors++;
            $display("FAIL end_last_word: got valid %b pc %h instr %h expected 0001 107c %h", instr_valid_out,
                     instr_pcs_out[0], instrs_out[0], word_at(l0_bytes, 60));
        end
    endtask

    task automatic test_miss();
        do_reset();
        randomize_lines();
        step(0, 1, 64'h2000, 0, 0, 0);
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL miss_accept: got %b expected 1", ready_seen); end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 64'h5000, 1, 0, 0);
            checks++;
            if (ready_seen !== 1'b0 || instr_valid_out !== 4'b0000) begin
                errors++;
                $display("FAIL miss_wait%0d: got ready %b valid %b expected 0 0000", k, ready_seen, instr_valid_out);
            end
        end
        step(0, 0, 64'h0, 0, 1, 0);
        checks++; if (instr_valid_out !== 4'b1111) begin errors++; $display("FAIL miss_fill_valid: got %b expected 1111", instr_valid_out); end
        for (int i = 0; i < SSW; i++) begin
            checks++;
            if (instr_pcs_out[i] !== 64'h2000 + 64'(4*i) || instrs_out[i] !== word_at(l1_bytes, 4*i)) begin
                errors++;
                $display("FAIL miss_fill_slot%0d: got pc %h instr %h expected pc %h instr %h", i,
                         instr_pcs_out[i], instrs_out[i], 64'h2000 + 64'(4*i), word_at(l1_bytes, 4*i));
            end
        end
    endtask

    task automatic test_flush_discard();
        do_reset();
        randomize_lines();
        step(0, 1, 64'h3000, 0, 0, 0);
        step(0, 0, 64'h0, 0, 0, 0);
        step(1, 0, 64'h0, 0, 0, 0);
        step(0, 0, 64'h0, 0, 0, 0);
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL discard_ready: got %b expected 0", ready_seen); end
        step(0, 0, 64'h0, 0, 1, 0);
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL discard_fill_ready: got %b expected 0", ready_seen); end
        checks++; if (instr_valid_out !== 4'b0000) begin errors++; $display("FAIL discard_dropped: got %b expected 0000", instr_valid_out); end
        step(0, 0, 64'h0, 0, 0, 0);
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL discard_ready_after: got %b expected 1", ready_seen); end
    endtask

    task automatic test_full();
        do_reset();
        randomize_lines();
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 64'(k*16), 1, 0, 0);
            checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %b expected 1", k, ready_seen); end
        end
        step(0, 1, 64'h40, 1, 0, 1);
        checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL full_ready_when_full: got %b expected 0", ready_seen); end
        checks++;
        if (instr_valid_out !== 4'b1111 || instr_pcs_out[0] !== 64'h10) begin
            errors++;
            $display("FAIL full_after_pop: got valid %b head pc %h expected 1111 10", instr_valid_out, instr_pcs_out[0]);
        end
        step(0, 0, 64'h0, 0, 0, 0);
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL full_ready_restored: got %b expected 1", ready_seen); end
    endtask

    task automatic test_flush_fill();
        do_reset();
        randomize_lines();
        step(0, 1, 64'h4000, 1, 0, 0);
        step(0, 1, 64'h4100, 0, 0, 0);
        checks++; if (ready_seen !== 1'b1) begin errors++; $display("FAIL ffill_miss_accept: got %b expected 1", ready_seen); end
        step(1, 0, 64'h0, 0, 1, 0);
        checks++; if (instr_valid_out !== 4'b0000) begin errors++; $display("FAIL ffill_cleared: got %b expected 0000", instr_valid_out); end
        step(0, 0, 64'h0, 0, 0, 0);
        checks++;
        if (ready_seen !== 1'b1 || instr_valid_out !== 4'b0000) begin
            errors++;
            $display("FAIL ffill_idle: got ready %b valid %b expected 1 0000", ready_seen, instr_valid_out);
        end
    endtask

    task automatic test_random();
        logic [SSW-1:0]          ev;
        logic [SSW-1:0][31:0]    ei;
        logic [SSW-1:0][PCW-1:0] ep;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            randomize_lines();
            step($urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, 64'($urandom) & 64'hFFFF,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4);
            checks++; if (ready_seen !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, ready_seen, exp_ready); end
            ev = '0; ei = '0; ep = '0;
            for (int i = 0; i < SSW; i++) begin
                if (i < mq.size()) begin
                    ev[i] = 1'b1;
                    ei[i] = mq[i].instr;
                    ep[i] = mq[i].pc;
                end
            end
            checks++; if (instr_valid_out !== ev) begin errors++; $display("FAIL rand_valid c%0d: got %b expected %b", c, instr_valid_out, ev); end
            checks++; if (instrs_out !== ei) begin errors++; $display("FAIL rand_instrs c%0d: got %h expected %h", c, instrs_out, ei); end
            checks++; if (instr_pcs_out !== ep) begin errors++; $display("FAIL rand_pcs c%0d: got %h expected %h", c, instr_pcs_out, ep); end
        end
    endtask

    initial begin
        rst_in = 1'b1; flush_in = 0; pc_valid_in = 0; pred_pc_in = '0;
        l0_valid_in = 0; l1i_valid_in = 0; decode_ready_in = 0;
        l0_cacheline_in = '0; l1i_cacheline_in = '0;
        m_mode = 0;
        m_pc   = '0;
        test_reset();
        test_l0_hit();
        test_line_end();
        test_miss();
        test_flush_discard();
        test_full();
        test_flush_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
